// File: rtl/dct_zigzag_quant.sv
// dct_zigzag_quant: captures one DCT_val x DCT_val coefficient matrix on a single-cycle
// valid pulse, then streams the coefficients out in zigzag order through a valid/ready
// handshake. Each coefficient is quantized by a rounded arithmetic right shift
// (round half away from zero).
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   val_input  one-cycle pulse, coef_in holds a valid matrix
//   coef_in    signed coefficient matrix [row][col], WIDTH bits each
//   in_ready   high when a matrix can be accepted (IDLE)
//   out_valid  out_coef/out_index/out_last are valid (SEND)
//   out_ready  consumer takes the current coefficient
//   out_coef   quantized coefficient, signed WIDTH bits
//   out_index  zigzag position of out_coef
//   out_last   high with the final coefficient of a block
//   drop_flag  sticky, a matrix arrived while busy; cleared only by reset
module dct_zigzag_quant #(
  parameter int unsigned DCT_val = 4,
  parameter int unsigned WIDTH   = 13,
  parameter int unsigned QSHIFT  = 2
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        val_input,
  input  logic [DCT_val-1:0][DCT_val-1:0][WIDTH-1:0]  coef_in,
  output logic                                        in_ready,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [WIDTH-1:0]                            out_coef,
  output logic [$clog2(DCT_val*DCT_val)-1:0]          out_index,
  output logic                                        out_last,
  output logic                                        drop_flag
);

  localparam int unsigned N   = DCT_val * DCT_val;
  localparam int unsigned IW  = $clog2(N);
  localparam int          DIM = int'(DCT_val);

  // Rounding offset 2^(QSHIFT-1); zero when no shift is applied.
  localparam logic signed [WIDTH:0] HALF =
    (QSHIFT == 0) ? '0 : (WIDTH+1)'(1 << (QSHIFT - 1));

  localparam logic StIdle = 1'b0;
  localparam logic StSend = 1'b1;

  // Row-major index of the k-th zigzag element, evaluated at elaboration.
  function automatic int zz_pos(input int k);
    int cnt;
    int res;
    int r;
    int c;
    cnt = 0;
    res = 0;
    for (int d = 0; d <= 2 * (DIM - 1); d++) begin
      for (int i = 0; i < DIM; i++) begin
        // Odd anti-diagonals walk downwards (row increasing), even ones upwards.
        r = (d % 2 == 1) ? i : (DIM - 1 - i);
        c = d - r;
        if (c >= 0 && c < DIM) begin
          if (cnt == k) res = r * DIM + c;
          cnt++;
        end
      end
    end
    return res;
  endfunction

  // One extra bit of headroom so that negating -2^(WIDTH-1) is exact.
  function automatic logic [WIDTH-1:0] quant(input logic [WIDTH-1:0] c);
    logic signed [WIDTH:0] ext;
    logic signed [WIDTH:0] mag;
    logic signed [WIDTH:0] rnd;
    ext = $signed({c[WIDTH-1], c});
    mag = '0;
    if (ext >= 0) begin
      rnd = (ext + HALF) >>> QSHIFT;
    end else begin
      mag = -ext;
      rnd = -((mag + HALF) >>> QSHIFT);
    end
    return rnd[WIDTH-1:0];
  endfunction

  logic [IW-1:0] zz_tbl [N];

  for (genvar k = 0; k < N; k++) begin : g_zz
    assign zz_tbl[k] = IW'(zz_pos(k));
  end

  logic                      state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d, idx_nxt;
  logic [N-1:0][WIDTH-1:0]   cap_q, cap_d, coef_flat;
  logic [WIDTH-1:0]          coef_q, coef_d;
  logic                      last_q, last_d;
  logic                      drop_q, drop_d;

  // Packed [row][col] flattens to row-major order: element r*DCT_val+c.
  assign coef_flat = coef_in;
  assign idx_nxt   = idx_q + IW'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cap_d   = cap_q;
    coef_d  = coef_q;
    last_d  = last_q;
    drop_d  = drop_q;
    case (state_q)
      StIdle: begin
        if (val_input) begin
          cap_d   = coef_flat;
          idx_d   = '0;
          // Quantize straight from the input so the first output is ready next cycle.
          coef_d  = quant(coef_flat[zz_tbl[0]]);
          last_d  = (N == 1);
          state_d = StSend;
        end
      end
      StSend: begin
        if (val_input) drop_d = 1'b1;
        if (out_ready) begin
          if (last_q) begin
            state_d = StIdle;
            idx_d   = '0;
            coef_d  = '0;
            last_d  = 1'b0;
          end else begin
            idx_d  = idx_nxt;
            coef_d = quant(cap_q[zz_tbl[idx_nxt]]);
            last_d = (idx_nxt == IW'(N - 1));
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cap_q   <= '0;
      coef_q  <= '0;
      last_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cap_q   <= cap_d;
      coef_q  <= coef_d;
      last_q  <= last_d;
      drop_q  <= drop_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StSend);
  assign out_coef  = coef_q;
  assign out_index = idx_q;
  assign out_last  = last_q;
  assign drop_flag = drop_q;

endmodule

// File: tb/tb_dct_zigzag_quant.sv
module tb_dct_zigzag_quant;

  localparam int D = 4;
  localparam int W = 13;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main DUT, QSHIFT=2
  logic                         val_input = 1'b0;
  logic [D-1:0][D-1:0][W-1:0]   coef_in = '0;
  logic                         in_ready, out_valid, out_last, drop_flag;
  logic                         out_ready = 1'b1;
  logic [W-1:0]                 out_coef;
  logic [3:0]                   out_index;

  // Pass-through DUT, QSHIFT=0, consumer always ready
  logic                         val0 = 1'b0;
  logic [D-1:0][D-1:0][W-1:0]   coef0 = '0;
  logic                         in_ready0, out_valid0, out_last0, drop0;
  logic [W-1:0]                 out_coef0;
  logic [3:0]                   out_index0;

  dct_zigzag_quant #(.DCT_val(4), .WIDTH(13), .QSHIFT(2)) u_dut (
    .clk(clk), .reset(rst_n), .val_input(val_input), .coef_in(coef_in),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_coef(out_coef), .out_index(out_index), .out_last(out_last),
    .drop_flag(drop_flag)
  );

  dct_zigzag_quant #(.DCT_val(4), .WIDTH(13), .QSHIFT(0)) u_dut0 (
    .clk(clk), .reset(rst_n), .val_input(val0), .coef_in(coef0),
    .in_ready(in_ready0), .out_valid(out_valid0), .out_ready(1'b1),
    .out_coef(out_coef0), .out_index(out_index0), .out_last(out_last0),
    .drop_flag(drop0)
  );

  typedef struct {
    int coef;
    int idx;
    bit last;
  } exp_t;

  exp_t q[$];
  exp_t q0[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int xfers    = 0;
  int cap_cyc  = 0;
  int mode     = 0;

  int zz_ref [16]      = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};
  int special_in [16]  = '{6, -6, 5, -5, 1, -2, -4096, 4095, 0, 0, 0, 0, 0, 0, 0, 0};
  int special_exp [16] = '{2, -2, 0, 0, -1, 1, -1, -1024, 0, 0, 0, 0, 1024, 0, 0, 0};
  int pat [4]          = '{1, 0, 0, 1};
  int va [16];
  int ea [16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Ready pattern driver: mode 0 holds ready high, mode 1 cycles 1,0,0,1.
  initial begin
    int pc;
    pc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mode == 0) begin
        out_ready = 1'b1;
      end else begin
        out_ready = pat[pc % 4][0];
        pc++;
      end
    end
  end

  // Monitor for the main DUT: scoreboard pop on every transfer plus hold checks.
  initial begin
    logic         pv, pr, pl;
    logic [W-1:0] pcf;
    logic [3:0]   pi;
    exp_t         e;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pcf = '0; pi = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          check("hold_valid", out_valid, 1);
          check("hold_coef", $signed(out_coef), $signed(pcf));
          check("hold_index", out_index, pi);
          check("hold_last", out_last, pl);
        end
        if (out_valid && out_ready) begin
          xfers++;
          if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_xfer: got coef %0d index %0d, expected no transfer",
                     $signed(out_coef), out_index);
          end else begin
            e = q.pop_front();
            check("coef", $signed(out_coef), e.coef);
            check("index", out_index, e.idx);
            check("last", out_last, e.last);
          end
        end
        pv = out_valid; pr = out_ready; pcf = out_coef; pi = out_index; pl = out_last;
      end
    end
  end

  // Monitor for the pass-through DUT.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid0) begin
        if (q0.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_xfer0: got coef %0d, expected no transfer",
                   $signed(out_coef0));
        end else begin
          e = q0.pop_front();
          check("ramp_coef", $signed(out_coef0), e.coef);
          check("ramp_index", out_index0, e.idx);
          check("ramp_last", out_last0, e.last);
        end
      end
    end
  end

  // Row-major values 4*(k+base) quantize exactly to k+base under QSHIFT=2.
  task automatic make_ramp(input int base);
    for (int k = 0; k < N; k++) va[k] = 4 * (k + base);
    for (int i = 0; i < N; i++) ea[i] = zz_ref[i] + base;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the capturing edge.
  task automatic issue(input int vals [16], input int ev [16]);
    exp_t e;
    for (int k = 0; k < N; k++) coef_in[k / D][k % D] = W'(vals[k]);
    for (int i = 0; i < N; i++) begin
      e.coef = ev[i];
      e.idx  = i;
      e.last = (i == N - 1);
      q.push_back(e);
    end
    val_input = 1'b1;
    @(posedge clk);
    #1;
    cap_cyc   = cyc;
    val_input = 1'b0;
    check("first_valid_latency", out_valid, 1);
  endtask

  task automatic wait_idle(input string name);
    int  n;
    bit  ok;
    n = 0;
    ok = 1'b0;
    while (n < 300 && !ok) begin
      @(posedge clk);
      #1;
      n++;
      if (in_ready && q.size() == 0) ok = 1'b1;
    end
    check({name, "_done"}, ok, 1);
  endtask

  task automatic wait_index(input int idx);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    while (n < 100 && !ok) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid && out_index == idx) ok = 1'b1;
    end
    check("reach_index", ok, 1);
  endtask

  task automatic wait_ready();
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    while (n < 100 && !ok) begin
      @(posedge clk);
      #1;
      n++;
      if (in_ready) ok = 1'b1;
    end
    check("reach_in_ready", ok, 1);
  endtask

  initial begin
    exp_t e;
    int   x0;
    int   c1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_coef", $signed(out_coef), 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_last", out_last, 0);
    check("rst_drop_flag", drop_flag, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ramp through the QSHIFT=0 instance.
    for (int k = 0; k < N; k++) coef0[k / D][k % D] = W'(k);
    for (int i = 0; i < N; i++) begin
      e.coef = zz_ref[i];
      e.idx  = i;
      e.last = (i == N - 1);
      q0.push_back(e);
    end
    val0 = 1'b1;
    @(posedge clk);
    #1;
    val0 = 1'b0;
    check("ramp_latency", out_valid0, 1);
    repeat (16) @(posedge clk);
    #1;
    check("ramp_16_cycles", q0.size(), 0);
    check("ramp_back_idle", in_ready0, 1);

    // Rounding corner cases.
    issue(special_in, special_exp);
    wait_idle("special");

    // Backpressure.
    mode = 1;
    x0 = xfers;
    make_ramp(-50);
    issue(va, ea);
    wait_idle("backpressure");
    mode = 0;
    check("bp_xfers", xfers - x0, 16);

    // Busy drop at index 5, then earliest re-accept.
    make_ramp(0);
    issue(va, ea);
    wait_index(5);
    check("busy_in_ready", in_ready, 0);
    make_ramp(100);
    for (int k = 0; k < N; k++) coef_in[k / D][k % D] = W'(va[k]);
    val_input = 1'b1;
    @(posedge clk);
    #1;
    val_input = 1'b0;
    check("drop_flag_set", drop_flag, 1);
    wait_ready();
    make_ramp(7);
    issue(va, ea);
    wait_idle("after_drop");
    check("drop_flag_sticky", drop_flag, 1);

    // Reset mid-block at index 7.
    make_ramp(20);
    issue(va, ea);
    wait_index(7);
    rst_n = 1'b0;
    q.delete();
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_coef", $signed(out_coef), 0);
    check("mid_rst_out_index", out_index, 0);
    check("mid_rst_out_last", out_last, 0);
    check("mid_rst_drop_flag", drop_flag, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("post_rst_no_valid", out_valid, 0);
    end
    make_ramp(-3);
    issue(va, ea);
    check("post_rst_drop_flag", drop_flag, 0);
    wait_idle("post_reset");

    // Back-to-back at earliest in_ready.
    make_ramp(1);
    issue(va, ea);
    c1 = cap_cyc;
    wait_ready();
    make_ramp(2);
    issue(va, ea);
    check("b2b_period", cap_cyc - c1, 17);
    wait_idle("b2b");

    check("q0_empty", q0.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dct_zigzag_quant.md
Name: dct_zigzag_quant

Overview:
- Downstream stage of the DCT matrix block in the hardware encoder.
- Captures one DCT_val x DCT_val coefficient matrix on a single-cycle valid pulse and quantizes each coefficient by a rounded arithmetic right shift.
- Emits the quantized coefficients one per handshake in zigzag order, ready for entropy coding.

Parameters:
- DCT_val, 4, matrix dimension; supported values 2, 4, 8.
- WIDTH, 13, coefficient width, two's complement, for both input and output.
- QSHIFT, 2, quantization shift amount, range 0..WIDTH-2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- val_input  in  1  one-cycle pulse: coef_in holds a valid matrix this cycle.
- coef_in  in  WIDTH x [DCT_val][DCT_val]  signed coefficient matrix [row][col], driven by the DCT result.
- in_ready  out  1  high when a matrix can be accepted.
- out_valid  out  1  out_coef is valid.
- out_ready  in  1  consumer accepts out_coef this cycle.
- out_coef  out  WIDTH  signed quantized coefficient.
- out_index  out  log2(DCT_val^2)  zigzag position 0..DCT_val^2-1 of out_coef.
- out_last  out  1  high with the final coefficient of a block.
- drop_flag  out  1  sticky: a matrix arrived while the block was busy.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; in_ready=1; out_valid=0; out_coef=0; out_index=0; out_last=0; drop_flag=0.
  - Capture register is cleared.
  - Reset asserted mid-block discards the block; no partial output follows release.
- FSM states: IDLE and SEND.
- IDLE:
  - in_ready=1, out_valid=0.
  - val_input=1 captures all of coef_in into an internal register, sets index=0, and moves to SEND.
- SEND:
  - in_ready=0; out_valid=1.
  - out_coef = Q(capture[zz(index)]); out_index=index; out_last = (index == DCT_val^2-1).
  - Outputs are registered and stay stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready, index increments.
  - If the transfer had out_last=1, the FSM returns to IDLE; in_ready rises the next cycle.
  - A new matrix is never accepted in the same cycle the last coefficient is taken.
- Latency: first coefficient appears on out_valid the cycle after the capturing edge.
- Throughput: one coefficient per cycle with out_ready held high. Minimum block period is DCT_val^2+1 cycles.
- Drop rule:
  - val_input=1 while in SEND: the matrix is ignored, the capture register is untouched, and drop_flag is set.
  - drop_flag clears only on reset.
- Zigzag order zz(k): row-major index r*DCT_val+c, walking anti-diagonals d=r+c=0..2(DCT_val-1).
  - Odd d runs top-right to bottom-left (r increasing).
  - Even d runs bottom-left to top-right (r decreasing).
  - DCT_val=4 sequence: 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15.
  - The table is generated at elaboration, not hand-entered.
- Quantization Q(c): round half away from zero, internal width WIDTH+1.
  - c >= 0: (c + H) >>> QSHIFT.
  - c < 0: -((-c + H) >>> QSHIFT).
  - H = 2^(QSHIFT-1), or 0 when QSHIFT=0.
  - QSHIFT=0 passes values through unchanged, including -2^(WIDTH-1).
  - The result always fits WIDTH bits, so no saturation is needed.
- out_ready is ignored while out_valid=0.
- coef_in is sampled only on the capture edge.

Test Plan:
- Ramp matrix, row-major values 0..15, QSHIFT=0, out_ready=1: out_coef = 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15 on 16 consecutive cycles. out_index=0..15. out_last only on value 15. First valid is 1 cycle after val_input.
- QSHIFT=2 with entries 6, -6, 5, -5, 1, -2, -4096, 4095: outputs 2, -2, 1, -1, 0, -1, -1024, 1024 at their zigzag positions.
- Backpressure: toggle out_ready 1,0,0,1 repeatedly. Each coefficient holds stable while stalled, none are lost or duplicated, and the total is 16 transfers.
- Busy drop: a second val_input pulse with a different matrix at index 5 sets drop_flag=1 and leaves the first block's stream unchanged. A pulse one cycle after last is taken is accepted normally.
- Reset at index 7: outputs return to reset values immediately, with no further out_valid. A new block after release starts at index 0 and drop_flag=0.
- Back-to-back: two blocks pulsed at the earliest in_ready. Block period is 17 cycles and both streams are correct.
